// File: rtl/mem_copy_master_pkg.sv
// Shared types and constants for the mem_copy_master block and its bus port.
package mem_copy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    GAP   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] MASK_ALL  = 4'hF;
  localparam logic [3:0] MASK_NONE = 4'h0;

  // Picks the operation that follows a completed write: finish after the
  // last word, otherwise either another write (fill) or the next read.
  function automatic state_t nextAfterWrite(input logic lastWord, input logic fill);
    state_t op;
    if (lastWord) begin
      op = DONE;
    end else if (fill) begin
      op = WRITE;
    end else begin
      op = READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_copy_master_if.sv
// sel/ack single-word memory bus. Signal names keep the initiator's view:
// *_o are driven by the master, *_i are driven by the responder.
interface mem_copy_master_if;

  logic        sel_o;
  logic        wr_en_o;
  logic [3:0]  wr_mask_o;
  logic [31:0] address_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic        ack_i;

  modport master (
    output sel_o,
    output wr_en_o,
    output wr_mask_o,
    output address_o,
    output data_o,
    input  data_i,
    input  ack_i
  );

  modport slave (
    input  sel_o,
    input  wr_en_o,
    input  wr_mask_o,
    input  address_o,
    input  data_o,
    output data_i,
    output ack_i
  );

endinterface

// File: rtl/mem_copy_master_bus_req_port.sv
// Bus request port for mem_copy_master. A launch pulse registers one
// request (read or write) and holds sel/address/data/write stable until the
// responder acks. sel drops at the ack edge and a launch is refused while a
// request is open, so a new request never starts in the ack cycle and sel
// is always low for at least one cycle between requests. The completion is
// reported as a single-cycle xfer_done; read data is captured at that edge.
module bus_req_port
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              reset_i,
  input  logic              i_launch,
  input  logic              i_write,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_xferDone,
  output logic [31:0]       o_rdata,
  mem_copy_master_if.master bus
);

  logic        r_sel;
  logic        r_wrEn;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_xferDone;

  assign w_xferDone = r_sel & bus.ack_i;

  // Open a request on launch, close it on ack and capture read data.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_sel   <= 1'b0;
      r_wrEn  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (i_launch && !r_sel) begin
      r_sel   <= 1'b1;
      r_wrEn  <= i_write;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (w_xferDone) begin
      r_sel <= 1'b0;
      if (!r_wrEn) begin
        r_rdata <= bus.data_i;
      end
    end
  end

  assign bus.sel_o     = r_sel;
  assign bus.wr_en_o   = r_sel & r_wrEn;
  assign bus.wr_mask_o = (r_sel && r_wrEn) ? MASK_ALL : MASK_NONE;
  assign bus.address_o = r_addr;
  assign bus.data_o    = r_wdata;

  assign o_xferDone = w_xferDone;
  assign o_rdata    = r_rdata;

endmodule

// File: rtl/mem_copy_master.sv
// mem_copy_master: copies len_i consecutive words from src_addr_i to
// dst_addr_i over the sel/ack bus, one read then one write per word, with a
// one-cycle gap after every ack so a trailing ack is never counted twice.
// Addresses are word indices and wrap modulo 2^32.
// Optional build macro MEM_COPY_FILL_EN adds fill_i/fill_data_i: with
// fill_i set at start every destination word gets fill_data_i, no reads.
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [31:0]       src_addr_i,
  input  logic [31:0]       dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill_i,
  input  logic [31:0]       fill_data_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  mem_copy_master_if.master bus
);

  state_t             r_state;
  state_t             r_nextOp;
  logic [31:0]        r_src;
  logic [31:0]        r_dst;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_fill;
  logic [31:0]        r_fillData;

  state_t             w_nextState;
  logic               w_launch;
  logic               w_launchWrite;
  logic [31:0]        w_launchAddr;
  logic [31:0]        w_launchData;
  logic               w_xferDone;
  logic [31:0]        w_rdata;
  logic               w_startFill;
  logic [31:0]        w_startFillData;
  logic               w_accept;

`ifdef MEM_COPY_FILL_EN
  assign w_startFill     = fill_i;
  assign w_startFillData = fill_data_i;
`else
  assign w_startFill     = 1'b0;
  assign w_startFillData = '0;
`endif

  assign w_accept = (r_state == IDLE) && start_i && (len_i != '0);

  bus_req_port u_port (
    .clk        (clk),
    .reset_i    (reset_i),
    .i_launch   (w_launch),
    .i_write    (w_launchWrite),
    .i_addr     (w_launchAddr),
    .i_wdata    (w_launchData),
    .o_xferDone (w_xferDone),
    .o_rdata    (w_rdata),
    .bus        (bus)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and bus launch decode; a request is launched in the cycle
  // before its state so sel is up on the first cycle of READ/WRITE.
  always_comb begin
    w_nextState   = r_state;
    w_launch      = 1'b0;
    w_launchWrite = 1'b0;
    w_launchAddr  = r_src;
    w_launchData  = w_rdata;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            w_launch      = 1'b1;
            w_launchWrite = w_startFill;
            w_launchAddr  = w_startFill ? dst_addr_i : src_addr_i;
            w_launchData  = w_startFillData;
            w_nextState   = w_startFill ? WRITE : READ;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      READ: begin
        if (w_xferDone) begin
          w_nextState = GAP;
        end
      end
      WRITE: begin
        if (w_xferDone) begin
          w_nextState = GAP;
        end
      end
      GAP: begin
        w_nextState = r_nextOp;
        if (r_nextOp == READ) begin
          w_launch     = 1'b1;
          w_launchAddr = r_src;
        end else if (r_nextOp == WRITE) begin
          w_launch      = 1'b1;
          w_launchWrite = 1'b1;
          w_launchAddr  = r_dst;
          w_launchData  = r_fill ? r_fillData : w_rdata;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Transfer parameters, word counters and the operation to run after GAP.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_fill      <= 1'b0;
      r_fillData  <= '0;
      r_nextOp    <= IDLE;
    end else if (w_accept) begin
      r_src       <= src_addr_i;
      r_dst       <= dst_addr_i;
      r_remaining <= len_i;
      r_fill      <= w_startFill;
      r_fillData  <= w_startFillData;
    end else if ((r_state == READ) && w_xferDone) begin
      r_nextOp <= WRITE;
    end else if ((r_state == WRITE) && w_xferDone) begin
      r_src       <= r_src + 32'd1;
      r_dst       <= r_dst + 32'd1;
      r_remaining <= r_remaining - LEN_W'(1);
      r_nextOp    <= nextAfterWrite(r_remaining == LEN_W'(1), r_fill);
    end
  end

  assign busy_o = (r_state == READ) || (r_state == GAP) || (r_state == WRITE);
  assign done_o = (r_state == DONE);

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master with a BRAM-style responder whose
// ack latency and address decode size are set per test.
`timescale 1ns/1ps
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
`ifdef MEM_COPY_FILL_EN
  logic        fill_i;
  logic [31:0] fill_data_i;
`endif
  logic        busy_o;
  logic        done_o;

  mem_copy_master_if busIf ();

  mem_copy_master #(.LEN_W(16)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
`ifdef MEM_COPY_FILL_EN
    .fill_i     (fill_i),
    .fill_data_i(fill_data_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .bus        (busIf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          ackLatency = 1;
  int          memMask = 127;
  logic [31:0] mem    [0:127];
  logic [31:0] expMem [0:127];
  logic        preloadEn = 1'b0;
  int          preloadAddr = 0;
  logic [31:0] preloadData = '0;

  int          selCnt = 0;
  int          readCount = 0;
  int          writeCount = 0;
  int          reqCount = 0;
  int          badGaps = 0;
  int          badMask = 0;
  int          unstable = 0;
  int          lowRun = 0;
  bit          prevSel = 1'b0;
  bit          runHadIdle = 1'b1;
  logic [31:0] lastAddr = '0;
  logic [31:0] lastData = '0;
  logic [31:0] readLog  [0:63];
  logic [31:0] writeLog [0:63];

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          latency;
    int          mask;
    int          expCycles;
  } vec_t;

  vec_t vecs [0:5];

  // BRAM responder: ack after ackLatency cycles of sel, held while sel is
  // high; the access happens once, on the cycle ack first rises.
  always @(posedge clk) begin
    if (preloadEn) begin
      mem[preloadAddr] <= preloadData;
    end
    if (busIf.sel_o) begin
      selCnt     <= selCnt + 1;
      lowRun     <= 0;
      runHadIdle <= 1'b0;
      if (!prevSel) begin
        reqCount <= reqCount + 1;
        if (!runHadIdle && lowRun != 1) begin
          badGaps <= badGaps + 1;
        end
      end else if (busIf.address_o != lastAddr || busIf.data_o != lastData) begin
        unstable <= unstable + 1;
      end
      if (selCnt + 1 == ackLatency) begin
        busIf.ack_i <= 1'b1;
        if (busIf.wr_en_o) begin
          mem[busIf.address_o & memMask] <= busIf.data_o;
          writeLog[writeCount & 63] <= busIf.address_o;
          writeCount <= writeCount + 1;
          if (busIf.wr_mask_o != 4'hF) badMask <= badMask + 1;
        end else begin
          busIf.data_i <= mem[busIf.address_o & memMask];
          readLog[readCount & 63] <= busIf.address_o;
          readCount <= readCount + 1;
          if (busIf.wr_mask_o != 4'h0) badMask <= badMask + 1;
        end
      end
    end else begin
      selCnt      <= 0;
      busIf.ack_i <= 1'b0;
      lowRun      <= lowRun + 1;
      if (!busy_o) runHadIdle <= 1'b1;
    end
    prevSel  <= busIf.sel_o;
    lastAddr <= busIf.address_o;
    lastData <= busIf.data_o;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic preloadMem(input int seed);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      preloadEn   = 1'b1;
      preloadAddr = i;
      preloadData = (32'(seed) << 16) | 32'(i);
      expMem[i]   = preloadData;
    end
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic preloadWord(input int addr, input logic [31:0] data);
    @(negedge clk);
    preloadEn    = 1'b1;
    preloadAddr  = addr;
    preloadData  = data;
    expMem[addr] = data;
    @(negedge clk);
    preloadEn = 1'b0;
  endtask

  task automatic shadowCopy(input logic [31:0] src, input logic [31:0] dst,
                            input int words, input int mask, input bit fill,
                            input logic [31:0] fillData);
    for (int k = 0; k < words; k++) begin
      if (fill) expMem[(dst + 32'(k)) & mask] = fillData;
      else expMem[(dst + 32'(k)) & mask] = expMem[(src + 32'(k)) & mask];
    end
  endtask

  task automatic checkMemory(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (mem[i] !== expMem[i]) bad++;
    end
    checkOutput(name, bad, 0);
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] src,
                               input logic [31:0] dst, input logic [15:0] len,
                               input int latency, input int mask, input bit fill,
                               input logic [31:0] fillData, input int expCycles);
    int baseR, baseW, baseReq, baseProto;
    int cycles, busyBad, bothHigh, addrBad;
    ackLatency = latency;
    memMask    = mask;
    baseR      = readCount;
    baseW      = writeCount;
    baseReq    = reqCount;
    baseProto  = badGaps + badMask + unstable;
    shadowCopy(src, dst, int'(len), mask, fill, fillData);
    @(negedge clk);
    start_i    = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
`ifdef MEM_COPY_FILL_EN
    fill_i      = fill;
    fill_data_i = fillData;
`endif
    @(posedge clk);
    #1 start_i = 1'b0;
    cycles   = 0;
    busyBad  = 0;
    bothHigh = 0;
    while (cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (done_o && busy_o) bothHigh++;
      if (done_o) break;
      if (!busy_o) busyBad++;
    end
    checkOutput({name, " cycles"}, cycles, expCycles);
    checkOutput({name, " busy"}, busyBad, 0);
    checkOutput({name, " done_busy"}, bothHigh, 0);
    @(negedge clk);
    checkOutput({name, " done_pulse"}, done_o, 1'b0);
    checkOutput({name, " writes"}, writeCount - baseW, int'(len));
    checkOutput({name, " reads"}, readCount - baseR, fill ? 0 : int'(len));
    checkOutput({name, " requests"}, reqCount - baseReq, fill ? int'(len) : 2 * int'(len));
    addrBad = 0;
    for (int k = 0; k < int'(len); k++) begin
      if (writeLog[(baseW + k) & 63] !== dst + 32'(k)) addrBad++;
      if (!fill && readLog[(baseR + k) & 63] !== src + 32'(k)) addrBad++;
    end
    checkOutput({name, " addresses"}, addrBad, 0);
    checkOutput({name, " protocol"}, badGaps + badMask + unstable - baseProto, 0);
    checkMemory({name, " memory"});
  endtask

  initial begin
    int found;
    int doneSeen;
    int baseW;
    logic [31:0] plan [0:3];

    vecs[0] = '{src: 32'h20,       dst: 32'h50, len: 16'd1, latency: 1, mask: 127, expCycles: 7};
    vecs[1] = '{src: 32'h30,       dst: 32'h60, len: 16'd0, latency: 1, mask: 127, expCycles: 1};
    vecs[2] = '{src: 32'h05,       dst: 32'h07, len: 16'd3, latency: 1, mask: 127, expCycles: 19};
    vecs[3] = '{src: 32'hFFFFFFFE, dst: 32'h04, len: 16'd3, latency: 1, mask: 31,  expCycles: 19};
    vecs[4] = '{src: 32'h10,       dst: 32'h48, len: 16'd4, latency: 3, mask: 127, expCycles: 41};
    vecs[5] = '{src: 32'h60,       dst: 32'h20, len: 16'd2, latency: 2, mask: 127, expCycles: 17};
    plan[0] = 32'd11;
    plan[1] = 32'd22;
    plan[2] = 32'd33;
    plan[3] = 32'd44;

    reset_i    = 1'b1;
    start_i    = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i      = '0;
`ifdef MEM_COPY_FILL_EN
    fill_i      = 1'b0;
    fill_data_i = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset sel", busIf.sel_o, 1'b0);
    checkOutput("reset wr_en", busIf.wr_en_o, 1'b0);
    checkOutput("reset mask", busIf.wr_mask_o, 4'h0);
    checkOutput("reset address", busIf.address_o, 32'h0);
    checkOutput("reset data", busIf.data_o, 32'h0);
    checkOutput("reset busy", busy_o, 1'b0);
    checkOutput("reset done", done_o, 1'b0);
    reset_i = 1'b0;

    $display("[TB] basic copy of four words");
    preloadMem(1);
    for (int k = 0; k < 4; k++) preloadWord(16 + k, plan[k]);
    applyStimulus("copy4", 32'h10, 32'h40, 16'd4, 1, 127, 1'b0, 32'h0, 25);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("copy4 word%0d", k), mem[64 + k], plan[k]);

    $display("[TB] vector table");
    for (int v = 0; v < 6; v++) begin
      preloadMem(v + 2);
      applyStimulus($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
                    vecs[v].latency, vecs[v].mask, 1'b0, 32'h0, vecs[v].expCycles);
    end

    $display("[TB] reset during write of word 2");
    preloadMem(20);
    ackLatency = 3;
    memMask    = 127;
    baseW      = writeCount;
    shadowCopy(32'h10, 32'h70, 2, 127, 1'b0, 32'h0);
    @(negedge clk);
    start_i    = 1'b1;
    src_addr_i = 32'h10;
    dst_addr_i = 32'h70;
    len_i      = 16'd4;
    @(posedge clk);
    #1 start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (busIf.sel_o && busIf.wr_en_o && busIf.address_o == 32'h72) begin
        found = 1;
        break;
      end
    end
    checkOutput("reset locate", found, 1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset drop sel", busIf.sel_o, 1'b0);
    checkOutput("reset drop busy", busy_o, 1'b0);
    @(negedge clk);
    reset_i  = 1'b0;
    doneSeen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o) doneSeen++;
    end
    checkOutput("reset no done", doneSeen, 0);
    checkOutput("reset writes", writeCount - baseW, 2);
    checkMemory("reset memory");
    applyStimulus("after reset", 32'h10, 32'h70, 16'd4, 3, 127, 1'b0, 32'h0, 41);

`ifdef MEM_COPY_FILL_EN
    $display("[TB] fill mode");
    preloadMem(30);
    applyStimulus("fill5", 32'h0, 32'h8, 16'd5, 1, 127, 1'b1, 32'hDEADBEEF, 16);
    for (int k = 0; k < 5; k++) checkOutput($sformatf("fill5 word%0d", k), mem[8 + k], 32'hDEADBEEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator that drives the team's sel/ack single-word memory bus, the same bus the on-chip BRAM responds on.
- On a start pulse it copies len_i consecutive 32-bit words from src_addr_i to dst_addr_i, one read and then one write per word.
- Sits between the CPU register interface (start/params/status) and a memory-bus responder port.
- Addresses are word indices, the same convention the responders use, not byte addresses.

Parameters:
- LEN_W, 16, width of the word-count input and the internal remaining-word counter.

Ports:
- clk  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle request; sampled only in IDLE
- src_addr_i  input  32  first source word address
- dst_addr_i  input  32  first destination word address
- len_i  input  LEN_W  number of words to copy
- busy_o  output  1  high from the cycle after an accepted start until the DONE state
- done_o  output  1  one-cycle pulse on completion
- sel_o  output  1  bus request
- wr_en_o  output  1  1 = write, 0 = read
- wr_mask_o  output  4  byte enables; 4'hF on writes, 4'h0 on reads
- address_o  output  32  bus word address
- data_o  output  32  write data
- data_i  input  32  read data, valid in the cycle ack_i is high
- ack_i  input  1  responder acknowledge

Behaviour:
- Interface (already decided): one clock, clk; reset_i is synchronous and active-high.
- Reset values: every output is 0; state IDLE; internal registers cleared.
- Reset mid-transfer: sel_o drops at that edge, no done_o pulse, the in-flight word is abandoned.
- States: IDLE, READ, GAP, WRITE, DONE.
- IDLE:
  - start_i with len_i != 0: latch src, dst, len; go to READ.
  - start_i with len_i == 0: go to DONE; no bus cycle.
  - start_i in any other state is ignored.
- READ:
  - sel_o=1, wr_en_o=0, address_o=src; signals held stable until ack_i.
  - On ack_i: capture data_i into the data register; go to GAP with next-op=WRITE.
- WRITE:
  - sel_o=1, wr_en_o=1, wr_mask_o=4'hF, address_o=dst, data_o=captured word; held until ack_i.
  - On ack_i: src+1, dst+1, remaining-1.
  - Then go to GAP with next-op=READ if remaining after the decrement is nonzero, else next-op=DONE.
- GAP:
  - Exactly one cycle with sel_o=0; ack_i is ignored here.
  - Purpose: absorb the trailing ack a responder raises one cycle after sel, so a held sel is never double-counted.
  - Proceeds to next-op.
- DONE: done_o=1 for one cycle, busy_o=0; back to IDLE. done_o and busy_o are never high together.
- Timing against a 1-cycle-ack responder: READ 2 + GAP 1 + WRITE 2 + GAP 1 = 6 cycles per word.
  - Total from the start edge to done_o = 6*len + 1 cycles.
  - Slow responders simply extend READ/WRITE; there is no timeout.
- Arithmetic: addresses increment modulo 2^32 (0xFFFFFFFF wraps to 0). remaining is LEN_W bits, so the maximum is 2^LEN_W-1 words.
- Overlapping regions: always copied in ascending order. With dst > src, the source pattern propagates; this is defined behaviour, not an error.
- ack_i seen outside READ/WRITE is ignored.

Optional Feature:
- Macro: MEM_COPY_FILL_EN.
- Defined:
  - Adds ports fill_i (input, 1) and fill_data_i (input, 32), latched at start.
  - With fill_i=1 the READ state is skipped: IDLE→WRITE, and GAP after WRITE goes to WRITE.
  - Every destination word receives fill_data_i; 3 cycles per word; source address unused.
- Undefined: the ports are absent; copy only.

Decomposition:
- Package mem_copy_pkg:
  - state_t enum {IDLE, READ, GAP, WRITE, DONE};
  - constant MASK_ALL = 4'hF;
  - constant MASK_NONE = 4'h0.
- One natural sub-module, bus_req_port: holds sel/addr/data/wr stable until ack, generates the one-cycle GAP, and reports a single-cycle "xfer_done" with the captured data_i. The top module keeps only the counters and sequencing.

Test Plan:
- BRAM responder preloaded with mem[0x10..0x13] = 11,22,33,44; start src=0x10 dst=0x40 len=4 -> mem[0x40..0x43] = 11,22,33,44; done_o exactly 25 cycles after the start edge; busy_o high throughout.
- len=0 -> done_o one cycle after start, sel_o never asserted.
- src=0xFFFFFFFE len=3 (32-entry BRAM model, address decoded mod size) -> reads at 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; write addresses also increment by one per word.
- Responder with 3-cycle ack latency and ack held while sel is high -> exactly one write per destination word, no skipped or duplicated word, sel_o low for one cycle between every request.
- reset_i asserted during the WRITE of word 2 of 4 -> sel_o=0 at the next edge, no done_o, dst words 2..3 unchanged; a new start after reset completes normally.
- MEM_COPY_FILL_EN defined, fill_i=1, fill_data_i=0xDEADBEEF, dst=0x8, len=5 -> mem[0x8..0xC] all 0xDEADBEEF, no read cycles, done_o 16 cycles after start.
